infrared_tx: RTL and testbench

NEC-protocol infrared transmitter. It pairs with the existing IR receiver and sits beside it as an additional Avalon-MM slave in the media-center peripheral set. Software writes a 32-bit frame, or requests a repeat code. The block produces the leader, pulse-distance-coded bits and stop mark on a 38 kHz modulated output, and raises an interrupt on completion.

---
 rtl/infrared_tx_pkg.sv | 44 ++++
 rtl/infrared_tx_if.sv | 38 +++
 rtl/infrared_tx_carrier_gen.sv | 36 +++
 rtl/infrared_tx.sv | 210 +++++++++++++++++++++
 tb/tb_infrared_tx.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/infrared_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | infrared_tx_pkg                                                      |
// | Shared types and constants for the NEC infrared transmitter.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package infrared_tx_pkg;

  // Protocol phases of one NEC transmission.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5
  } ir_state_t;

  // Phase durations, in units of one 562.5 us tick.
  localparam logic [4:0] LEAD_MARK_T    = 5'd16;
  localparam logic [4:0] LEAD_SPACE_T   = 5'd8;
  localparam logic [4:0] REPEAT_SPACE_T = 5'd4;
  localparam logic [4:0] ONE_SPACE_T    = 5'd3;
  localparam logic [4:0] UNIT_T         = 5'd1;

  // CTRL/STATUS register bit positions.
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_DONE   = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_OVR    = 3;
  localparam int CTRL_REPEAT = 4;

  // Clock cycles per 562.5 us tick; widened so fast clocks do not overflow.
  function automatic int tick_cycles(input int clk_hz);
    return int'((longint'(clk_hz) * 64'sd9) / 64'sd16000);
  endfunction

  // Clock cycles per carrier half-period, truncated.
  function automatic int half_cycles(input int clk_hz, input int carrier_hz);
    return clk_hz / (2 * carrier_hz);
  endfunction

endpackage
`default_nettype wire

// File: rtl/infrared_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | infrared_tx_if                                                       |
// | Avalon-MM slave port bundle for the infrared transmitter.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface infrared_tx_if;

  logic        avs_s1_address;
  logic        avs_s1_cs_n;
  logic        avs_s1_read;
  logic [31:0] avs_s1_readdata;
  logic        avs_s1_write;
  logic [31:0] avs_s1_writedata;
  logic        avs_s1_irq;

  modport master (
    output avs_s1_address,
    output avs_s1_cs_n,
    output avs_s1_read,
    output avs_s1_write,
    output avs_s1_writedata,
    input  avs_s1_readdata,
    input  avs_s1_irq
  );

  modport slave (
    input  avs_s1_address,
    input  avs_s1_cs_n,
    input  avs_s1_read,
    input  avs_s1_write,
    input  avs_s1_writedata,
    output avs_s1_readdata,
    output avs_s1_irq
  );

endinterface
`default_nettype wire

// File: rtl/infrared_tx_carrier_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ir_carrier_gen                                                       |
// | 50% duty carrier: toggles every HALF cycles, restartable so that a   |
// | mark always begins with a full high half-period.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ir_carrier_gen #(
  parameter int HALF = 657
) (
  input  logic csi_clk,
  input  logic csi_reset_n,
  input  logic restart,
  output logic carrier
);

  localparam int            CW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic [CW-1:0] half_cnt;

  // Count out each half-period and flip the carrier at its end; restart re-phases high.
  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n || restart) begin
      half_cnt <= '0;
      carrier  <= 1'b1;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      carrier  <= ~carrier;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/infrared_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | infrared_tx                                                          |
// | NEC-protocol infrared transmitter with Avalon-MM register file,      |
// | tick timer, protocol FSM and 38 kHz modulated output.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module infrared_tx
  import infrared_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int CARRIER_HZ = 38_000
) (
  input  logic         csi_clk,
  input  logic         csi_reset_n,
  infrared_tx_if.slave avs,
  output logic         coe_ir_tx
);

  localparam int            TICK      = tick_cycles(CLK_HZ);
  localparam int            HALF      = half_cycles(CLK_HZ, CARRIER_HZ);
  localparam int            TW        = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

  ir_state_t state;
  ir_state_t state_nxt;

  logic [31:0]   frame;
  logic          is_repeat;
  logic          ie;
  logic          done;
  logic          ovr;

  logic [TW-1:0] tick_cnt;
  logic [4:0]    unit_cnt;
  logic [4:0]    bit_idx;
  logic [4:0]    units;

  logic          wr_en;
  logic          rd_en;
  logic          wr_data;
  logic          wr_ctrl;
  logic          repeat_req;
  logic          start_frame;
  logic          start_repeat;
  logic          start;
  logic          reject;
  logic          tick_last;
  logic          state_end;
  logic          busy;
  logic          mark;
  logic          mark_nxt;
  logic          restart;
  logic          done_set;
  logic          carrier;

  // ---------------------------------------------------------------------
  // Bus decode. A start is only honoured while idle; any start attempt
  // while busy is dropped and flagged as an overrun instead.
  // ---------------------------------------------------------------------
  assign wr_en        = !avs.avs_s1_cs_n && avs.avs_s1_write;
  assign rd_en        = !avs.avs_s1_cs_n && avs.avs_s1_read;
  assign wr_data      = wr_en && !avs.avs_s1_address;
  assign wr_ctrl      = wr_en &&  avs.avs_s1_address;
  assign repeat_req   = wr_ctrl && avs.avs_s1_writedata[CTRL_REPEAT];
  assign start_frame  = wr_data    && !busy;
  assign start_repeat = repeat_req && !busy;
  assign start        = start_frame || start_repeat;
  assign reject       = busy && (wr_data || repeat_req);

  // Length of the current phase in ticks, from the phase and the bit being sent.
  always_comb begin
    units = UNIT_T;
    case (state)
      ST_LEAD_MARK:  units = LEAD_MARK_T;
      ST_LEAD_SPACE: units = is_repeat ? REPEAT_SPACE_T : LEAD_SPACE_T;
      ST_BIT_MARK:   units = UNIT_T;
      ST_BIT_SPACE:  units = frame[bit_idx] ? ONE_SPACE_T : UNIT_T;
      ST_STOP_MARK:  units = UNIT_T;
      default:       units = UNIT_T;
    endcase
  end

  assign tick_last = (tick_cnt == TICK_LAST);
  assign state_end = tick_last && (unit_cnt == (units - UNIT_T));

  // State register.
  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: walk leader, 32 LSB-first bits (skipped for a repeat), stop mark.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LEAD_MARK;
      end
      ST_LEAD_MARK: begin
        if (state_end) state_nxt = ST_LEAD_SPACE;
      end
      ST_LEAD_SPACE: begin
        if (state_end) state_nxt = is_repeat ? ST_STOP_MARK : ST_BIT_MARK;
      end
      ST_BIT_MARK: begin
        if (state_end) state_nxt = ST_BIT_SPACE;
      end
      ST_BIT_SPACE: begin
        if (state_end) state_nxt = (bit_idx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
      end
      ST_STOP_MARK: begin
        if (state_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; marks never follow marks, so entering one is a non-mark to mark step.
  always_comb begin
    busy     = (state != ST_IDLE);
    mark     = (state == ST_LEAD_MARK) || (state == ST_BIT_MARK) ||
               (state == ST_STOP_MARK);
    mark_nxt = (state_nxt == ST_LEAD_MARK) || (state_nxt == ST_BIT_MARK) ||
               (state_nxt == ST_STOP_MARK);
    restart  = mark_nxt && !mark;
    done_set = (state == ST_STOP_MARK) && state_end;
  end

  // Tick and per-phase tick counters, plus the bit index advanced after each bit space.
  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
      bit_idx  <= '0;
    end else if (state == ST_IDLE) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
      bit_idx  <= '0;
    end else if (state_end) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
      if (state == ST_BIT_SPACE) bit_idx <= bit_idx + 5'd1;
    end else if (tick_last) begin
      tick_cnt <= '0;
      unit_cnt <= unit_cnt + 5'd1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Register file: set events take priority over software clears of done/ovr.
  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      frame     <= '0;
      is_repeat <= 1'b0;
      ie        <= 1'b0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      if (start_frame) frame <= avs.avs_s1_writedata;
      if (start) is_repeat <= start_repeat;
      if (wr_ctrl) ie <= avs.avs_s1_writedata[CTRL_IE];

      if (done_set) begin
        done <= 1'b1;
      end else if (wr_ctrl && avs.avs_s1_writedata[CTRL_DONE]) begin
        done <= 1'b0;
      end

      if (reject) begin
        ovr <= 1'b1;
      end else if (wr_ctrl && avs.avs_s1_writedata[CTRL_OVR]) begin
        ovr <= 1'b0;
      end
    end
  end

  // Zero-wait-state read mux; drives zero whenever no read is in progress.
  always_comb begin
    avs.avs_s1_readdata = '0;
    if (rd_en) begin
      if (avs.avs_s1_address) begin
        avs.avs_s1_readdata[CTRL_BUSY] = busy;
        avs.avs_s1_readdata[CTRL_DONE] = done;
        avs.avs_s1_readdata[CTRL_IE]   = ie;
        avs.avs_s1_readdata[CTRL_OVR]  = ovr;
      end else begin
        avs.avs_s1_readdata = frame;
      end
    end
  end

  assign avs.avs_s1_irq = done && ie;
  assign coe_ir_tx      = mark && carrier;

  ir_carrier_gen #(
    .HALF (HALF)
  ) u_carrier (
    .csi_clk     (csi_clk),
    .csi_reset_n (csi_reset_n),
    .restart     (restart),
    .carrier     (carrier)
  );

endmodule
`default_nettype wire

// File: tb/tb_infrared_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_infrared_tx                                                       |
// | Self-checking bench: expected IR waveforms are built from the NEC    |
// | timing rules as lists of (mark/space, length) segments.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_infrared_tx;

  localparam int CLK_HZ     = 160_000;
  localparam int CARRIER_HZ = 38_000;
  localparam int TICK       = CLK_HZ * 9 / 16000;        // 90
  localparam int HALF       = CLK_HZ / (2 * CARRIER_HZ); // 2

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ir_tx;

  int total = 0;
  int bad   = 0;

  logic [31:0] last_frame = 32'h0;

  int          seg_len[$];
  bit          seg_mark[$];
  logic        tr_tx[$];
  logic        tr_irq[$];
  logic [31:0] tr_st[$];

  infrared_tx_if bus ();

  infrared_tx #(
    .CLK_HZ     (CLK_HZ),
    .CARRIER_HZ (CARRIER_HZ)
  ) dut (
    .csi_clk     (clk),
    .csi_reset_n (rst_n),
    .avs         (bus),
    .coe_ir_tx   (ir_tx)
  );

  always #5 clk = ~clk;

  // All bus tasks are entered at a falling edge; writes are sampled at the next rising edge.
  task automatic bus_write(input logic addr, input logic [31:0] data);
    bus.avs_s1_address   = addr;
    bus.avs_s1_writedata = data;
    bus.avs_s1_cs_n      = 1'b0;
    bus.avs_s1_write     = 1'b1;
    @(negedge clk);
    bus.avs_s1_cs_n      = 1'b1;
    bus.avs_s1_write     = 1'b0;
  endtask

  task automatic bus_read(input logic addr, output logic [31:0] data);
    bus.avs_s1_address = addr;
    bus.avs_s1_cs_n    = 1'b0;
    bus.avs_s1_read    = 1'b1;
    #1;
    data = bus.avs_s1_readdata;
    bus.avs_s1_cs_n    = 1'b1;
    bus.avs_s1_read    = 1'b0;
  endtask

  function automatic void add_seg(input int ticks, input bit is_mark);
    seg_len.push_back(ticks * TICK);
    seg_mark.push_back(is_mark);
  endfunction

  // Reference: NEC frame as mark/space segments (leader, LSB-first bits, stop).
  function automatic int model_frame(input logic [31:0] f, input bit rep);
    int sum = 0;
    seg_len.delete();
    seg_mark.delete();
    add_seg(16, 1'b1);
    add_seg(rep ? 4 : 8, 1'b0);
    if (!rep) begin
      for (int b = 0; b < 32; b++) begin
        add_seg(1, 1'b1);
        add_seg(f[b] ? 3 : 1, 1'b0);
      end
    end
    add_seg(1, 1'b1);
    foreach (seg_len[k]) sum += seg_len[k];
    return sum;
  endfunction

  // Record output, irq and status once per cycle, starting at the current falling edge.
  task automatic capture(input int n);
    logic [31:0] s;
    tr_tx.delete();
    tr_irq.delete();
    tr_st.delete();
    for (int i = 0; i < n; i++) begin
      tr_tx.push_back(ir_tx);
      tr_irq.push_back(bus.avs_s1_irq);
      bus_read(1'b1, s);
      tr_st.push_back(s);
      @(negedge clk);
    end
  endtask

  // Compare the trace to the model, segment by segment, then check the completion edge.
  task automatic check_trace(input string name, input int t_len);
    int   pos = 0;
    int   diffs;
    logic expv;
    foreach (seg_len[k]) begin
      diffs = 0;
      for (int o = 0; o < seg_len[k]; o++) begin
        expv = seg_mark[k] ? (((o / HALF) % 2) == 0) : 1'b0;
        if (tr_tx[pos + o] !== expv) diffs++;
      end
      total++;
      if (diffs != 0) begin
        bad++;
        $display("FAIL %s seg%0d %s len=%0d: %0d cycles differ from model, required 0",
                 name, k, seg_mark[k] ? "mark" : "space", seg_len[k], diffs);
      end
      pos += seg_len[k];
    end
    total++;
    if (tr_st[0][0] !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_at_start: got %b, required 1", name, tr_st[0][0]);
    end
    total++;
    if (tr_st[t_len-1][1] !== 1'b0 || tr_irq[t_len-1] !== 1'b0 || tr_st[t_len-1][0] !== 1'b1) begin
      bad++;
      $display("FAIL %s before_end: status=%h irq=%b, required busy=1 done=0 irq=0",
               name, tr_st[t_len-1], tr_irq[t_len-1]);
    end
    total++;
    if (tr_st[t_len][1:0] !== 2'b10 || tr_irq[t_len] !== 1'b1 || tr_tx[t_len] !== 1'b0) begin
      bad++;
      $display("FAIL %s at_end(%0d): status=%h irq=%b tx=%b, required done=1 busy=0 irq=1 tx=0",
               name, t_len, tr_st[t_len], tr_irq[t_len], tr_tx[t_len]);
    end
  endtask

  // Send one frame or repeat (ie=1 already), check waveform, then acknowledge done.
  task automatic run_frame(input string name, input logic [31:0] f, input bit rep);
    int          t_len;
    logic [31:0] s;
    t_len = model_frame(f, rep);
    if (rep) begin
      bus_write(1'b1, 32'h0000_0014);
    end else begin
      bus_write(1'b0, f);
      last_frame = f;
    end
    capture(t_len + 2);
    check_trace(name, t_len);
    bus_read(1'b0, s);
    total++;
    if (s !== last_frame) begin
      bad++;
      $display("FAIL %s data_reg: got %h, required %h", name, s, last_frame);
    end
    bus_write(1'b1, 32'h0000_0006);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_0004) begin
      bad++;
      $display("FAIL %s done_clear: status=%h, required 00000004", name, s);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    logic [31:0] s;
    int          n = 0;
    bus_read(1'b1, s);
    while (s[0] && n < limit) begin
      @(negedge clk);
      bus_read(1'b1, s);
      n++;
    end
    total++;
    if (s[0] !== 1'b0) begin
      bad++;
      $display("FAIL %s wait_idle: still busy after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic test_reset();
    logic [31:0] s;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ir_tx !== 1'b0 || bus.avs_s1_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: tx=%b irq=%b, required 0 0", ir_tx, bus.avs_s1_irq);
    end
    total++;
    if (bus.avs_s1_readdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_idle_readdata: got %h, required 0", bus.avs_s1_readdata);
    end
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0) begin
      bad++;
      $display("FAIL reset_status: got %h, required 0", s);
    end
    bus_read(1'b0, s);
    total++;
    if (s !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got %h, required 0", s);
    end
    last_frame = 32'h0;
  endtask

  task automatic test_frames();
    logic [31:0] s;
    bus_write(1'b1, 32'h0000_0004);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_0004 || bus.avs_s1_irq !== 1'b0) begin
      bad++;
      $display("FAIL ie_set: status=%h irq=%b, required 00000004 0", s, bus.avs_s1_irq);
    end
    run_frame("frame_20df", 32'h00FF_20DF, 1'b0);
    run_frame("frame_zero", 32'h0000_0000, 1'b0);
    run_frame("frame_ones", 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_repeat();
    run_frame("repeat", 32'h0, 1'b1);
  endtask

  task automatic test_overrun();
    logic [31:0] a;
    logic [31:0] s;
    a = $urandom;
    bus_write(1'b0, a);
    last_frame = a;
    repeat (20) @(negedge clk);
    bus_write(1'b0, ~a);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_000D) begin
      bad++;
      $display("FAIL ovr_data_busy: status=%h, required 0000000d", s);
    end
    bus_read(1'b0, s);
    total++;
    if (s !== a) begin
      bad++;
      $display("FAIL ovr_frame_kept: got %h, required %h", s, a);
    end
    bus_write(1'b1, 32'h0000_000C);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_0005) begin
      bad++;
      $display("FAIL ovr_clear: status=%h, required 00000005", s);
    end
    bus_write(1'b1, 32'h0000_0014);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_000D) begin
      bad++;
      $display("FAIL ovr_repeat_busy: status=%h, required 0000000d", s);
    end
    bus_write(1'b1, 32'h0000_000C);
    wait_idle("overrun", 20000);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_0006) begin
      bad++;
      $display("FAIL ovr_finish: status=%h, required 00000006", s);
    end
    bus_write(1'b1, 32'h0000_0006);
  endtask

  task automatic test_reset_mid();
    logic [31:0] f;
    logic [31:0] s;
    int          odd;
    f = $urandom | 32'h1;
    bus_write(1'b0, f);
    last_frame = f;
    // Bit 0 is a 1, so its space spans cycles 2250..2519 after the start.
    repeat (2300) @(negedge clk);
    bus_read(1'b1, s);
    total++;
    if (s[0] !== 1'b1 || ir_tx !== 1'b0) begin
      bad++;
      $display("FAIL midrst_pre: status=%h tx=%b, required busy=1 tx=0", s, ir_tx);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_frame = 32'h0;
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0 || ir_tx !== 1'b0 || bus.avs_s1_irq !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after: status=%h tx=%b irq=%b, required 0 0 0", s, ir_tx, bus.avs_s1_irq);
    end
    odd = 0;
    for (int i = 0; i < 300; i++) begin
      bus_read(1'b1, s);
      if (ir_tx !== 1'b0 || s !== 32'h0) odd++;
      @(negedge clk);
    end
    total++;
    if (odd != 0) begin
      bad++;
      $display("FAIL midrst_quiet: %0d active cycles after reset, required 0", odd);
    end
    bus_write(1'b1, 32'h0000_0004);
    run_frame("after_reset", $urandom, 1'b0);
  endtask

  task automatic test_end_collision();
    logic [31:0] s;
    int          t_len;
    t_len = model_frame(32'h0, 1'b1);
    // Clear of done lands on the very edge that sets it.
    bus_write(1'b1, 32'h0000_0014);
    repeat (t_len - 1) @(negedge clk);
    bus_read(1'b1, s);
    total++;
    if (s[1:0] !== 2'b01) begin
      bad++;
      $display("FAIL coll_pre: status=%h, required busy=1 done=0", s);
    end
    bus_write(1'b1, 32'h0000_0006);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_0006) begin
      bad++;
      $display("FAIL coll_done_wins: status=%h, required 00000006", s);
    end
    bus_write(1'b1, 32'h0000_0006);
    // DATA write on the edge busy falls is still treated as busy.
    bus_write(1'b1, 32'h0000_0014);
    repeat (t_len - 1) @(negedge clk);
    bus_write(1'b0, 32'hA5A5_5A5A);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_000E) begin
      bad++;
      $display("FAIL coll_start_ovr: status=%h, required 0000000e", s);
    end
    bus_read(1'b0, s);
    total++;
    if (s !== last_frame) begin
      bad++;
      $display("FAIL coll_frame_kept: got %h, required %h", s, last_frame);
    end
    bus_write(1'b1, 32'h0000_000E);
    repeat (5) @(negedge clk);
    bus_read(1'b1, s);
    total++;
    if (s !== 32'h0000_0004 || ir_tx !== 1'b0) begin
      bad++;
      $display("FAIL coll_final: status=%h tx=%b, required 00000004 0", s, ir_tx);
    end
  endtask

  initial begin
    bus.avs_s1_address   = 1'b0;
    bus.avs_s1_cs_n      = 1'b1;
    bus.avs_s1_read      = 1'b0;
    bus.avs_s1_write     = 1'b0;
    bus.avs_s1_writedata = 32'h0;
    @(negedge clk);
    test_reset();
    test_frames();
    test_repeat();
    test_overrun();
    test_reset_mid();
    test_end_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
